// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//
// Generates the select for the N-to-1 switch mux. The select steps one position per debounced
// key press, or automatically at a fixed rate when auto mode is enabled. A registered one-hot
// copy of the select drives the board LEDs.
//
// Ports:
//   CLOCK_50    in   system clock
//   RESET_N     in   asynchronous active-low reset
//   STEP_N      in   raw pushbutton, active-low, asynchronous, bouncy
//   AUTO_EN     in   raw switch, 1 = auto-step, asynchronous
//   DIR         in   raw switch, 0 = increment, 1 = decrement, asynchronous
//   SEL         out  registered mux select, always within 0..NUM_IN-1
//   SEL_ONEHOT  out  registered one-hot copy of SEL
//   STEP        out  one-cycle pulse in the cycle SEL first shows a new value
module mux_sel_sequencer #(
  parameter int unsigned NUM_IN     = 5,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              STEP_N,
  input  logic              AUTO_EN,
  input  logic              DIR,
  output logic [SEL_W-1:0]  SEL,
  output logic [NUM_IN-1:0] SEL_ONEHOT,
  output logic              STEP
);

  localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Two-flop synchronisers; the key idles high so its flops reset to 1.
  logic key_meta_q, key_sync_q;
  logic auto_meta_q, auto_sync_q;
  logic dir_meta_q, dir_sync_q;

  // Debouncer and press edge detector.
  logic            deb_key_q, deb_key_d;
  logic            deb_key_prev_q;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            man_req_q, man_req_d;

  // Auto-step prescaler.
  logic [TickW-1:0] presc_q, presc_d;
  logic             tick;

  // Select state.
  logic              advance;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_IN-1:0] onehot_q, onehot_d;
  logic              step_q, step_d;

  // Debounce: count only while the synchronised key disagrees with the accepted level; any
  // agreement (a bounce back) restarts the count from zero.
  always_comb begin
    deb_key_d = deb_key_q;
    deb_cnt_d = '0;
    if (key_sync_q != deb_key_q) begin
      if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
        deb_key_d = key_sync_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  // Press only (1->0); release is ignored so a held key gives exactly one step.
  assign man_req_d = deb_key_prev_q & ~deb_key_q;

  assign tick = auto_sync_q && (presc_q == TickW'(TICK_DIV - 1));

  always_comb begin
    presc_d = '0;
    if (auto_sync_q && !tick) begin
      presc_d = presc_q + TickW'(1);
    end
  end

  // A manual request coinciding with a tick still advances only once.
  assign advance = man_req_q | tick;

  always_comb begin
    sel_d = sel_q;
    if (advance) begin
      if (!dir_sync_q) begin
        sel_d = (sel_q == SEL_W'(NUM_IN - 1)) ? '0 : sel_q + SEL_W'(1);
      end else begin
        sel_d = (sel_q == '0) ? SEL_W'(NUM_IN - 1) : sel_q - SEL_W'(1);
      end
    end
  end

  // Decode from sel_d so the LEDs change on the same edge as SEL.
  always_comb begin
    onehot_d = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      onehot_d[i] = (sel_d == SEL_W'(i));
    end
  end

  assign step_d = advance;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta_q     <= 1'b1;
      key_sync_q     <= 1'b1;
      auto_meta_q    <= 1'b0;
      auto_sync_q    <= 1'b0;
      dir_meta_q     <= 1'b0;
      dir_sync_q     <= 1'b0;
      deb_key_q      <= 1'b1;
      deb_key_prev_q <= 1'b1;
      deb_cnt_q      <= '0;
      man_req_q      <= 1'b0;
      presc_q        <= '0;
      sel_q          <= '0;
      onehot_q       <= NUM_IN'(1);
      step_q         <= 1'b0;
    end else begin
      key_meta_q     <= STEP_N;
      key_sync_q     <= key_meta_q;
      auto_meta_q    <= AUTO_EN;
      auto_sync_q    <= auto_meta_q;
      dir_meta_q     <= DIR;
      dir_sync_q     <= dir_meta_q;
      deb_key_q      <= deb_key_d;
      deb_key_prev_q <= deb_key_q;
      deb_cnt_q      <= deb_cnt_d;
      man_req_q      <= man_req_d;
      presc_q        <= presc_d;
      sel_q          <= sel_d;
      onehot_q       <= onehot_d;
      step_q         <= step_d;
    end
  end

  assign SEL        = sel_q;
  assign SEL_ONEHOT = onehot_q;
  assign STEP       = step_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer with short debounce and tick periods. Every STEP pulse is
// checked against a queue of expected select values pushed when the stimulus is applied.
module tb_mux_sel_sequencer;

  localparam int unsigned NumIn     = 5;
  localparam int unsigned SelW      = 3;
  localparam int unsigned DebCycles = 4;
  localparam int unsigned TickDiv   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             step_n;
  logic             auto_en;
  logic             dir;
  logic [SelW-1:0]  sel;
  logic [NumIn-1:0] sel_onehot;
  logic             step;

  always #5 clk = ~clk;

  mux_sel_sequencer #(
    .NUM_IN     (NumIn),
    .SEL_W      (SelW),
    .DEB_CYCLES (DebCycles),
    .TICK_DIV   (TickDiv)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .STEP_N     (step_n),
    .AUTO_EN    (auto_en),
    .DIR        (dir),
    .SEL        (sel),
    .SEL_ONEHOT (sel_onehot),
    .STEP       (step)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [SelW-1:0] exp_q[$];
  logic [SelW-1:0] mon_exp;

  typedef struct packed {
    logic            dir;
    logic [SelW-1:0] exp_sel;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: each STEP pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && step === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected step: STEP=1 with SEL=%0d, want no step", sel);
      end else begin
        mon_exp = exp_q.pop_front();
        check("step sel", 32'(sel), 32'(mon_exp));
        check("step onehot", 32'(sel_onehot), 32'd1 << mon_exp);
      end
    end
  end

  task automatic press(input logic d, input logic [SelW-1:0] e);
    exp_q.push_back(e);
    dir    = d;
    step_n = 1'b0;
    cycles(12);
    step_n = 1'b1;
    cycles(12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{dir: 1'b0, exp_sel: 3'd1};
    vecs[1] = '{dir: 1'b0, exp_sel: 3'd2};
    vecs[2] = '{dir: 1'b0, exp_sel: 3'd3};
    vecs[3] = '{dir: 1'b0, exp_sel: 3'd4};
    vecs[4] = '{dir: 1'b0, exp_sel: 3'd0};
    vecs[5] = '{dir: 1'b1, exp_sel: 3'd4};
    vecs[6] = '{dir: 1'b1, exp_sel: 3'd3};

    rst_n   = 1'b0;
    step_n  = 1'b1;
    auto_en = 1'b0;
    dir     = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    // Idle after reset: outputs stay at their reset values.
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      check("idle sel", 32'(sel), 32'd0);
      check("idle onehot", 32'(sel_onehot), 32'h01);
      check("idle step", 32'(step), 32'd0);
    end

    // Clean press: SEL moves on the 8th edge after the first low sample, once only.
    exp_q.push_back(3'd1);
    dir    = 1'b0;
    step_n = 1'b0;
    cycles(7);
    check("latency sel before", 32'(sel), 32'd0);
    check("latency step before", 32'(step), 32'd0);
    cycles(1);
    check("latency sel", 32'(sel), 32'd1);
    check("latency step", 32'(step), 32'd1);
    cycles(1);
    check("step width", 32'(step), 32'd0);
    cycles(18);
    step_n = 1'b1;
    cycles(12);
    check("held key sel", 32'(sel), 32'd1);
    check("held key queue", 32'(exp_q.size()), 32'd0);

    // Glitches one cycle shorter than the debounce window are ignored.
    for (int i = 0; i < 5; i++) begin
      step_n = 1'b0;
      cycles(3);
      step_n = 1'b1;
      cycles(3);
    end
    cycles(10);
    check("glitch sel", 32'(sel), 32'd1);

    // Table of clean presses with wrap in both directions.
    do_reset();
    check("reset sel", 32'(sel), 32'd0);
    for (int i = 0; i < 7; i++) begin
      press(vecs[i].dir, vecs[i].exp_sel);
      check("table sel", 32'(sel), 32'(vecs[i].exp_sel));
      check("table onehot", 32'(sel_onehot), 32'd1 << vecs[i].exp_sel);
    end
    check("table queue", 32'(exp_q.size()), 32'd0);

    // Auto mode: first step 10 edges after AUTO_EN changes, then every 8; a manual request
    // landing on a tick advances once.
    do_reset();
    dir = 1'b0;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    auto_en = 1'b1;
    cycles(9);
    check("auto first before", 32'(sel), 32'd0);
    cycles(1);
    check("auto first sel", 32'(sel), 32'd1);
    check("auto first step", 32'(step), 32'd1);
    cycles(8);
    check("auto second sel", 32'(sel), 32'd2);
    step_n = 1'b0;
    cycles(8);
    check("coincident sel", 32'(sel), 32'd3);
    check("coincident step", 32'(step), 32'd1);
    cycles(1);
    check("coincident step width", 32'(step), 32'd0);
    cycles(7);
    check("auto fourth sel", 32'(sel), 32'd4);
    auto_en = 1'b0;
    step_n  = 1'b1;
    cycles(20);
    check("auto off sel", 32'(sel), 32'd4);
    check("auto queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-debounce clears asynchronously, with no step afterwards.
    step_n = 1'b0;
    cycles(4);
    rst_n = 1'b0;
    #1;
    check("async rst sel", 32'(sel), 32'd0);
    check("async rst onehot", 32'(sel_onehot), 32'h01);
    check("async rst step", 32'(step), 32'd0);
    step_n = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    check("post rst sel", 32'(sel), 32'd0);
    check("post rst queue", 32'(exp_q.size()), 32'd0);

    // Reset during auto mode, then auto stepping restarts from scratch.
    exp_q.push_back(3'd1);
    auto_en = 1'b1;
    cycles(13);
    check("auto pre rst sel", 32'(sel), 32'd1);
    rst_n = 1'b0;
    #1;
    check("auto rst sel", 32'(sel), 32'd0);
    check("auto rst onehot", 32'(sel_onehot), 32'h01);
    check("auto rst step", 32'(step), 32'd0);
    cycles(2);
    exp_q.push_back(3'd1);
    rst_n = 1'b1;
    cycles(9);
    check("auto restart before", 32'(sel), 32'd0);
    cycles(1);
    check("auto restart sel", 32'(sel), 32'd1);
    auto_en = 1'b0;
    cycles(20);
    check("auto restart queue", 32'(exp_q.size()), 32'd0);

    // Key held through reset yields one step once debounced after release.
    exp_q.push_back(3'd2);
    step_n = 1'b0;
    cycles(12);
    rst_n = 1'b0;
    cycles(2);
    exp_q.push_back(3'd1);
    rst_n = 1'b1;
    cycles(12);
    check("held through rst sel", 32'(sel), 32'd1);
    step_n = 1'b1;
    cycles(12);
    check("held through rst queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
